// File: rtl/photon_pkg.sv
// Shared types and constants for the photon trigger scheduler.
// The optional conversion timeout is enabled with PHOTON_TRIG_SCHED_TIMEOUT_EN.
package photon_pkg;

    // drop_cnt width; the counter saturates at all-ones
    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_CONVERT,
        ST_DEAD
    } state_t;

    // Saturating add of a per-cycle drop count (at most 8 simultaneous drops)
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] acc,
                                                  input logic [3:0]        inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, acc} + {{(DROP_W-3){1'b0}}, inc};
        return sum[DROP_W] ? DROP_MAX : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/photon_trig_sched_rr_pick.sv
// Combinational round-robin picker: first pending channel after 'last'.
// Search order is last+1, last+2, ... wrapping modulo NCH, ending at last.
module rr_pick #(
    parameter  int NCH = 4,
    localparam int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] pending,
    input  logic [CW-1:0]  last,
    output logic [CW-1:0]  grant,
    output logic           valid
);

    logic [CW:0] idx;

    // Scan farthest to nearest so the nearest pending channel is written last
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int off = NCH; off >= 1; off--) begin
            idx = {1'b0, last} + (CW+1)'(off);
            if (idx >= (CW+1)'(NCH))
                idx = idx - (CW+1)'(NCH);
            if (pending[idx[CW-1:0]]) begin
                grant = idx[CW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/photon_trig_sched.sv
// Photon trigger scheduler: synchronises per-channel trigger pulses, queues
// them as pending requests and serialises them onto one shared ADC, then
// holds the channel's integrator in reset for DEAD_CYC cycles.
// Define PHOTON_TRIG_SCHED_TIMEOUT_EN to abort conversions after TMO_CYC cycles.
module photon_trig_sched
    import photon_pkg::*;
#(
    parameter  int NCH      = 4,
    parameter  int DEAD_CYC = 8,
    parameter  int TMO_CYC  = 64,
    localparam int CW       = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    trig_in,
    output logic              conv_start,
    output logic [CW-1:0]     conv_ch,
    input  logic              conv_done,
    output logic [NCH-1:0]    int_rst,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              tmo_err
);

    state_t         state;
    logic [NCH-1:0] sync1, sync2, sync3;
    logic [NCH-1:0] trig_edge;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] active_mask;
    logic [NCH-1:0] drop_mask;
    logic [NCH-1:0] grant_mask;
    logic [CW-1:0]  last_grant;
    logic [CW-1:0]  pick_ch;
    logic           pick_valid;
    logic           grant_fire;
    logic [7:0]     dead_cnt;
`ifdef PHOTON_TRIG_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0]  tmo_cnt;
`endif

    // Two-flop synchroniser plus a third flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= trig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign trig_edge = sync2 & ~sync3;

    // Channel currently owning the ADC or integrator reset cannot re-queue
    assign active_mask = (state == ST_CONVERT || state == ST_DEAD) ?
                         (NCH'(1) << conv_ch) : '0;
    assign drop_mask   = trig_edge & (pending | active_mask);
    assign grant_fire  = (state == ST_IDLE) && pick_valid;
    assign grant_mask  = grant_fire ? (NCH'(1) << pick_ch) : '0;

    rr_pick #(.NCH(NCH)) u_rr_pick (
        .pending (pending),
        .last    (last_grant),
        .grant   (pick_ch),
        .valid   (pick_valid)
    );

    // Pending request set/clear and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= (pending & ~grant_mask) | (trig_edge & ~drop_mask);
            drop_cnt <= sat_add(drop_cnt, 4'($countones(drop_mask)));
        end
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= CW'(NCH - 1);
            conv_start <= 1'b0;
            conv_ch    <= '0;
            int_rst    <= '0;
            busy       <= 1'b0;
            dead_cnt   <= '0;
`ifdef PHOTON_TRIG_SCHED_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_err    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state      <= ST_GRANT;
                        conv_start <= 1'b1;
                        conv_ch    <= pick_ch;
                        last_grant <= pick_ch;
                        busy       <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    conv_start <= 1'b0;
                    state      <= ST_CONVERT;
`ifdef PHOTON_TRIG_SCHED_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        state    <= ST_DEAD;
                        int_rst  <= NCH'(1) << conv_ch;
                        dead_cnt <= 8'(DEAD_CYC - 1);
                    end
`ifdef PHOTON_TRIG_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                        state    <= ST_DEAD;
                        int_rst  <= NCH'(1) << conv_ch;
                        dead_cnt <= 8'(DEAD_CYC - 1);
                        tmo_err  <= 1'b1;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_DEAD: begin
                    if (dead_cnt == '0) begin
                        state   <= ST_IDLE;
                        int_rst <= '0;
                        busy    <= 1'b0;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef PHOTON_TRIG_SCHED_TIMEOUT_EN
    assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_photon_trig_sched.sv
// Self-checking bench for photon_trig_sched (default parameters).
// Expected grant channels are queued by the stimulus and checked by a monitor.
module tb_photon_trig_sched;

    localparam int NCH      = 4;
    localparam int DEAD_CYC = 8;
    localparam int TMO_CYC  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] trig_in = '0;
    logic       conv_done = 1'b0;
    logic       conv_start;
    logic [1:0] conv_ch;
    logic [3:0] int_rst;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       tmo_err;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int start_seen = 0;
    logic prev_start = 1'b0;

    photon_trig_sched #(
        .NCH(NCH), .DEAD_CYC(DEAD_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig_in(trig_in),
        .conv_start(conv_start), .conv_ch(conv_ch), .conv_done(conv_done),
        .int_rst(int_rst), .busy(busy), .drop_cnt(drop_cnt), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every conv_start must match the next queued channel and last one cycle
    always @(negedge clk) begin
        if (rst_n && conv_start) begin
            start_seen++;
            check("start_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
                check("grant_ch", 32'(conv_ch), 32'(exp_q.pop_front()));
            check("start_one_cycle", 32'(prev_start), 0);
        end
        prev_start = conv_start;
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        trig_in   = '0;
        conv_done = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive a one-cycle trigger pulse starting at the current negedge
    task automatic pulse(input logic [3:0] mask);
        trig_in = mask;
        @(negedge clk);
        trig_in = '0;
    endtask

    task automatic wait_start(output int lat);
        logic found = 1'b0;
        lat = 0;
        while (!found && lat < 20) begin
            @(negedge clk);
            lat++;
            found = conv_start;
        end
        check("start_seen", 32'(found), 1);
    endtask

    // Called while in DEAD: measure the integrator-reset window
    task automatic count_dead(input int ch);
        int n = 0;
        int wrong = 0;
        check("conv_ch_hold", 32'(conv_ch), 32'(ch));
        while (int_rst != 0 && n < 40) begin
            if (int_rst != (4'b0001 << ch)) wrong++;
            n++;
            @(negedge clk);
        end
        check("dead_len", 32'(n), DEAD_CYC);
        check("int_rst_onehot", 32'(wrong), 0);
        check("busy_after_dead", 32'(busy), 0);
    endtask

    // Called at the negedge where conv_start is seen
    task automatic finish_conv(input int ch);
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        count_dead(ch);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s0;
        int n;

        do_reset();
        check("rst_conv_start", 32'(conv_start), 0);
        check("rst_conv_ch", 32'(conv_ch), 0);
        check("rst_int_rst", 32'(int_rst), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_tmo_err", 32'(tmo_err), 0);

        // Single pulse on ch2: latency, dead window, busy drop
        exp_q.push_back(2);
        pulse(4'b0100);
        wait_start(lat);
        check("latency", 32'(lat + 1), 4);
        check("busy_in_grant", 32'(busy), 1);
        finish_conv(2);

        // ch0 and ch3 together after reset: ch0 first, then ch3
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(3);
        pulse(4'b1001);
        wait_start(lat);
        finish_conv(0);
        wait_start(lat);
        finish_conv(3);
        check("drop_none", 32'(drop_cnt), 0);

        // Second ch1 edge during its own DEAD is dropped and not re-granted
        exp_q.push_back(1);
        pulse(4'b0010);
        wait_start(lat);
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        fork
            pulse(4'b0010);
            count_dead(1);
        join
        check("drop_in_dead", 32'(drop_cnt), 1);
        s0 = start_seen;
        repeat (20) @(negedge clk);
        check("no_regrant", 32'(start_seen - s0), 0);

        // Drop flood while ch0 converts and ch1 waits pending
        do_reset();
        exp_q.push_back(0);
        pulse(4'b0001);
        wait_start(lat);
        pulse(4'b0010);
        @(negedge clk);
        for (int i = 0; i < 127; i++) begin
            pulse(4'b0011);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("drop_254", 32'(drop_cnt), 254);
        pulse(4'b0011);
        repeat (4) @(negedge clk);
        check("drop_sat_pair", 32'(drop_cnt), 255);
        for (int i = 0; i < 22; i++) begin
            pulse(4'b0011);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("drop_300", 32'(drop_cnt), 255);
        exp_q.push_back(1);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        count_dead(0);
        wait_start(lat);
        finish_conv(1);
        check("drop_hold", 32'(drop_cnt), 255);

        // Missing conv_done
        do_reset();
        exp_q.push_back(3);
        pulse(4'b1000);
        wait_start(lat);
`ifdef PHOTON_TRIG_SCHED_TIMEOUT_EN
        @(negedge clk);
        n = 0;
        while (int_rst == 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("tmo_convert_len", 32'(n), TMO_CYC);
        check("tmo_err_set", 32'(tmo_err), 1);
        count_dead(3);
        check("tmo_err_sticky", 32'(tmo_err), 1);
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && int_rst == 0) n++;
        end
        check("stay_convert", 32'(n), 100);
        check("tmo_err_zero", 32'(tmo_err), 0);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        count_dead(3);
`endif

        // Reset in the middle of DEAD with ch1 pending
        do_reset();
        exp_q.push_back(2);
        pulse(4'b0100);
        wait_start(lat);
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        pulse(4'b0010);
        repeat (3) @(negedge clk);
        check("int_rst_before_reset", 32'(int_rst), 4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_int_rst", 32'(int_rst), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_conv_ch", 32'(conv_ch), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_seen;
        repeat (20) @(negedge clk);
        check("pending_cleared", 32'(start_seen - s0), 0);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_int_rst", 32'(int_rst), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
